step2_1: RTL
============

STEP2_1 -- requirements
Module: step2_1

Interface
REQ-001 Port clk, input, 1: single clock; all logic on rising edge.
REQ-002 Port rst, input, 1: synchronous active-high reset.
REQ-003 Port din_valid, input, 1: din_r/din_i carry one valid 16-lane beat this cycle.
REQ-004 Port din_r[0:15], input, 16 x 14 signed: real lanes from step2_0 dout_r.
REQ-005 Port din_i[0:15], input, 16 x 14 signed: imaginary lanes from step2_0 dout_i.
REQ-006 Port dout_valid, output, 1: dout_r/dout_i hold one result beat.
REQ-007 Port dout_frame_start, output, 1: high with the first beat (c=0) of each 32-beat frame.
REQ-008 Port dout_r[0:15], output, 16 x 15 signed: real results.
REQ-009 Port dout_i[0:15], output, 16 x 15 signed: imaginary results.

Function
REQ-010 Frame = 32 valid beats; 5-bit beat counter c counts valid beats only, 0..31, wraps 31->0; c holds while din_valid low.
REQ-011 Stage 1 (registered on din_valid): for j=0..7, sum S_j = din[j] + din[j+8], diff D_j = din[j] - din[j+8], both complex, 15-bit signed, full precision with no overflow possible.
REQ-012 Stage 1 also registers c and a valid bit; a cycle without din_valid clears the stage-1 valid bit and leaves the stage-1 data registers unchanged.
REQ-013 Twiddle exponent e_j = (j * c) mod 64; twiddle W = cos - j*sin of angle 2*pi*e_j/64; cos and sin are 10-bit signed Q1.8, with 256 = 1.0, rounded to nearest, range -256..256.
REQ-014 Stage 2 (registered): dout[j] = S_j passed unchanged; dout[j+8] = D_j * W.
REQ-015 Complex multiply: re = Dr*cos + Di*sin; im = Di*cos - Dr*sin; products and sum are carried at full width, at least 26 bits.
REQ-016 Rounding: add 128, then arithmetic shift right by 8.
REQ-017 Saturation: the rounded result is clamped to [-16384, 16383].
REQ-018 Latency: a beat accepted at cycle N appears at dout at cycle N+2; dout_valid is asserted at cycle N+2.
REQ-019 dout_frame_start = dout_valid AND (registered c == 0).
REQ-020 There is no backpressure; one beat per cycle is sustained indefinitely, and back-to-back frames need no gap cycle.
REQ-021 While dout_valid is low, dout_r and dout_i hold their last values.

Reset
REQ-022 On rst: c=0, stage-1 and stage-2 valid bits = 0, dout_valid = 0, dout_frame_start = 0, dout_r and dout_i all lanes = 0.
REQ-023 Reset mid-frame discards all in-flight beats; the first valid beat after rst deasserts is c=0.
REQ-024 din_valid asserted during rst is ignored.

Structure
REQ-025 Package step2_pkg holds: the lane count (16), frame length (32), input width (14), output width (15), twiddle width (10), and the 64-entry COS and SIN constant ROM arrays.
REQ-026 Sub-module cmul_q8 implements one complex multiply with round and saturate (REQ-015..017) and is instantiated 8 times.
REQ-027 The ROM is combinationally indexed by e_j inside the stage-2 path.

Verification
REQ-028 Identity twiddle: beat c=0, din_r[0]=100, din_r[8]=50, all other lanes 0 -> 2 cycles later dout_r[0]=150, dout_r[8]=50, dout_i all 0, dout_frame_start=1.
REQ-029 -j twiddle: at c=16, j=1 (e=16), with D_1 = 300+j200 (din[1]=300+j200, din[9]=0) -> dout_r[9]=200, dout_i[9]=-300.
REQ-030 Saturation: at c=8, j=1 (e=8, cos=sin=181), with din[1]=8191+j8191 and din[9]=-8192-j8192 -> dout_r[9]=16383, dout_i[9]=0.
REQ-031 Gapped input: 32 beats with din_valid toggling every other cycle -> exactly 32 dout_valid pulses, frame_start only on the first, and c correct on every beat against the model.
REQ-032 Reset mid-frame: rst asserted after beat c=13, then a new frame -> no output for the discarded beats, and the next output beat has dout_frame_start=1.
REQ-033 Random back-to-back 3 frames: every output lane matches the bit-accurate reference model, checking wrap 31->0.

Source files
------------

// File: rtl/step2_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | step2_pkg : widths, lane/frame geometry and 64-point twiddle ROM         |
// | Rev 1.0   : initial release                                              |
// +--------------------------------------------------------------------------+
package step2_pkg;

   localparam int LANES     = 16;
   localparam int HALF      = LANES / 2;
   localparam int LANE_W    = $clog2(HALF);
   localparam int FRAME_LEN = 32;
   localparam int CNT_W     = $clog2(FRAME_LEN);
   localparam int IN_W      = 14;
   localparam int OUT_W     = 15;
   localparam int TW_W      = 10;
   localparam int ROM_DEPTH = 64;
   localparam int EXP_W     = $clog2(ROM_DEPTH);
   localparam int ACC_W     = OUT_W + TW_W + 1;
   localparam int RND_SHIFT = 8;

   localparam logic signed [ACC_W-1:0] C_RND_HALF = ACC_W'(1 << (RND_SHIFT - 1));
   localparam logic signed [ACC_W-1:0] C_SAT_HI   = ACC_W'((1 << (OUT_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] C_SAT_LO   = ACC_W'(-(1 << (OUT_W - 1)));

   // Q1.8 twiddles: round(256*cos(2*pi*k/64)) and round(256*sin(2*pi*k/64))
   localparam logic signed [TW_W-1:0] COS_ROM [0:ROM_DEPTH-1] = '{
      10'sd256,  10'sd255,  10'sd251,  10'sd245,  10'sd237,  10'sd226,  10'sd213,  10'sd198,
      10'sd181,  10'sd162,  10'sd142,  10'sd121,  10'sd98,   10'sd74,   10'sd50,   10'sd25,
      10'sd0,   -10'sd25,  -10'sd50,  -10'sd74,  -10'sd98,  -10'sd121, -10'sd142, -10'sd162,
     -10'sd181, -10'sd198, -10'sd213, -10'sd226, -10'sd237, -10'sd245, -10'sd251, -10'sd255,
     -10'sd256, -10'sd255, -10'sd251, -10'sd245, -10'sd237, -10'sd226, -10'sd213, -10'sd198,
     -10'sd181, -10'sd162, -10'sd142, -10'sd121, -10'sd98,  -10'sd74,  -10'sd50,  -10'sd25,
      10'sd0,    10'sd25,   10'sd50,   10'sd74,   10'sd98,   10'sd121,  10'sd142,  10'sd162,
      10'sd181,  10'sd198,  10'sd213,  10'sd226,  10'sd237,  10'sd245,  10'sd251,  10'sd255
   };

   localparam logic signed [TW_W-1:0] SIN_ROM [0:ROM_DEPTH-1] = '{
      10'sd0,    10'sd25,   10'sd50,   10'sd74,   10'sd98,   10'sd121,  10'sd142,  10'sd162,
      10'sd181,  10'sd198,  10'sd213,  10'sd226,  10'sd237,  10'sd245,  10'sd251,  10'sd255,
      10'sd256,  10'sd255,  10'sd251,  10'sd245,  10'sd237,  10'sd226,  10'sd213,  10'sd198,
      10'sd181,  10'sd162,  10'sd142,  10'sd121,  10'sd98,   10'sd74,   10'sd50,   10'sd25,
      10'sd0,   -10'sd25,  -10'sd50,  -10'sd74,  -10'sd98,  -10'sd121, -10'sd142, -10'sd162,
     -10'sd181, -10'sd198, -10'sd213, -10'sd226, -10'sd237, -10'sd245, -10'sd251, -10'sd255,
     -10'sd256, -10'sd255, -10'sd251, -10'sd245, -10'sd237, -10'sd226, -10'sd213, -10'sd198,
     -10'sd181, -10'sd162, -10'sd142, -10'sd121, -10'sd98,  -10'sd74,  -10'sd50,  -10'sd25
   };

   function automatic logic signed [OUT_W-1:0] ext_in(input logic signed [IN_W-1:0] x);
      return OUT_W'(x);
   endfunction

   // (lane * beat) mod 64; the 8-bit product keeps every bit before truncation
   function automatic logic [EXP_W-1:0] tw_exp(input logic [LANE_W-1:0] lane,
                                               input logic [CNT_W-1:0]  cnt);
      logic [CNT_W+LANE_W-1:0] p;
      p = {{CNT_W{1'b0}}, lane} * {{LANE_W{1'b0}}, cnt};
      return p[EXP_W-1:0];
   endfunction

   function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] x);
      if (x > C_SAT_HI)
         return C_SAT_HI[OUT_W-1:0];
      else if (x < C_SAT_LO)
         return C_SAT_LO[OUT_W-1:0];
      else
         return x[OUT_W-1:0];
   endfunction

endpackage : step2_pkg
`default_nettype wire

// File: rtl/cmul_q8.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cmul_q8 : complex multiply by a Q1.8 twiddle, round-half-up, saturate     |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
module cmul_q8
   import step2_pkg::*;
(
   input  logic signed [OUT_W-1:0] i_dr,
   input  logic signed [OUT_W-1:0] i_di,
   input  logic signed [TW_W-1:0]  i_cos,
   input  logic signed [TW_W-1:0]  i_sin,
   output logic signed [OUT_W-1:0] o_re,
   output logic signed [OUT_W-1:0] o_im
);

   logic signed [ACC_W-1:0] w_dr;
   logic signed [ACC_W-1:0] w_di;
   logic signed [ACC_W-1:0] w_cos;
   logic signed [ACC_W-1:0] w_sin;
   logic signed [ACC_W-1:0] w_re_acc;
   logic signed [ACC_W-1:0] w_im_acc;
   logic signed [ACC_W-1:0] w_re_rnd;
   logic signed [ACC_W-1:0] w_im_rnd;

   // Operands widened first so every product is formed at accumulator width
   assign w_dr  = ACC_W'(i_dr);
   assign w_di  = ACC_W'(i_di);
   assign w_cos = ACC_W'(i_cos);
   assign w_sin = ACC_W'(i_sin);

   // Multiplying by conj rotation: W = cos - j*sin
   assign w_re_acc = w_dr * w_cos + w_di * w_sin;
   assign w_im_acc = w_di * w_cos - w_dr * w_sin;

   assign w_re_rnd = (w_re_acc + C_RND_HALF) >>> RND_SHIFT;
   assign w_im_rnd = (w_im_acc + C_RND_HALF) >>> RND_SHIFT;

   assign o_re = sat_out(w_re_rnd);
   assign o_im = sat_out(w_im_rnd);

endmodule : cmul_q8
`default_nettype wire

// File: rtl/step2_1.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | step2_1 : radix-2 butterfly on 16 lanes plus per-beat twiddle, 2 cycles   |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
module step2_1
   import step2_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    din_valid,
   input  logic signed [IN_W-1:0]  din_r [0:LANES-1],
   input  logic signed [IN_W-1:0]  din_i [0:LANES-1],
   output logic                    dout_valid,
   output logic                    dout_frame_start,
   output logic signed [OUT_W-1:0] dout_r [0:LANES-1],
   output logic signed [OUT_W-1:0] dout_i [0:LANES-1]
);

   logic [CNT_W-1:0]        r_cnt;

   logic                    r_s1_valid;
   logic [CNT_W-1:0]        r_s1_cnt;
   logic signed [OUT_W-1:0] r_s_r [0:HALF-1];
   logic signed [OUT_W-1:0] r_s_i [0:HALF-1];
   logic signed [OUT_W-1:0] r_d_r [0:HALF-1];
   logic signed [OUT_W-1:0] r_d_i [0:HALF-1];

   logic signed [OUT_W-1:0] w_tw_r [0:HALF-1];
   logic signed [OUT_W-1:0] w_tw_i [0:HALF-1];

   logic                    r_dout_valid;
   logic                    r_frame_start;
   logic signed [OUT_W-1:0] r_dout_r [0:LANES-1];
   logic signed [OUT_W-1:0] r_dout_i [0:LANES-1];

   // Beat index within the frame; advances only on accepted beats
   always_ff @(posedge clk) begin
      if (rst)
         r_cnt <= '0;
      else if (din_valid)
         r_cnt <= r_cnt + CNT_W'(1);
   end

   // Stage 1: butterfly sums/differences, held across idle cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_cnt   <= '0;
         for (int j = 0; j < HALF; j++) begin
            r_s_r[j] <= '0;
            r_s_i[j] <= '0;
            r_d_r[j] <= '0;
            r_d_i[j] <= '0;
         end
      end else begin
         r_s1_valid <= din_valid;
         if (din_valid) begin
            r_s1_cnt <= r_cnt;
            for (int j = 0; j < HALF; j++) begin
               r_s_r[j] <= ext_in(din_r[j]) + ext_in(din_r[j+HALF]);
               r_s_i[j] <= ext_in(din_i[j]) + ext_in(din_i[j+HALF]);
               r_d_r[j] <= ext_in(din_r[j]) - ext_in(din_r[j+HALF]);
               r_d_i[j] <= ext_in(din_i[j]) - ext_in(din_i[j+HALF]);
            end
         end
      end
   end

   generate
      for (genvar j = 0; j < HALF; j++) begin : g_twiddle
         logic [EXP_W-1:0] w_exp;

         assign w_exp = tw_exp(LANE_W'(j), r_s1_cnt);

         cmul_q8 u_cmul (
            .i_dr  (r_d_r[j]),
            .i_di  (r_d_i[j]),
            .i_cos (COS_ROM[w_exp]),
            .i_sin (SIN_ROM[w_exp]),
            .o_re  (w_tw_r[j]),
            .o_im  (w_tw_i[j])
         );
      end
   endgenerate

   // Stage 2: output register; data only moves when stage 1 held a beat
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dout_valid  <= 1'b0;
         r_frame_start <= 1'b0;
         for (int k = 0; k < LANES; k++) begin
            r_dout_r[k] <= '0;
            r_dout_i[k] <= '0;
         end
      end else begin
         r_dout_valid  <= r_s1_valid;
         r_frame_start <= r_s1_valid && (r_s1_cnt == '0);
         if (r_s1_valid) begin
            for (int j = 0; j < HALF; j++) begin
               r_dout_r[j]      <= r_s_r[j];
               r_dout_i[j]      <= r_s_i[j];
               r_dout_r[j+HALF] <= w_tw_r[j];
               r_dout_i[j+HALF] <= w_tw_i[j];
            end
         end
      end
   end

   assign dout_valid       = r_dout_valid;
   assign dout_frame_start = r_frame_start;

   generate
      for (genvar k = 0; k < LANES; k++) begin : g_out
         assign dout_r[k] = r_dout_r[k];
         assign dout_i[k] = r_dout_i[k];
      end
   endgenerate

endmodule : step2_1
`default_nettype wire
